// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared state enum and constants for the serial multi-hot encoder
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    NONE = 2'd2
  } enc_state_t;

  localparam int ENC_N_MAX     = 64;
  localparam int ENC_CODE_NONE = 0;

endpackage

// File: rtl/priority_index_enc.sv
// rtl/priority_index_enc.sv - combinational set-bit index picker; ENCODER_MSB_FIRST_EN selects highest-first
module priority_index_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         onehot_only
);

  // Later loop iterations win, so the scan order decides which end has priority.
  always_comb begin
    idx = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
`endif
  end

  assign onehot_only = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/encoder_serial_multi_hot.sv
// rtl/encoder_serial_multi_hot.sv - emits the index of each set bit of a captured vector, one per beat
// Optional ENCODER_MSB_FIRST_EN (in priority_index_enc) emits highest index first.
module encoder_serial_multi_hot
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  enc_state_t   state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic [W-1:0] idx;
  logic         onehot;
  logic         act;

  priority_index_enc #(.N(N), .W(W)) u_pick (
    .vec         (pending),
    .idx         (idx),
    .onehot_only (onehot)
  );

  // Reset and enable both blank every output; state only advances while active.
  assign act = en & ~rst;

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_code    = '0;
    out_last    = 1'b0;
    out_none    = 1'b0;
    busy        = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    if (act) begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            pending_nxt = in_vec;
            state_nxt   = (in_vec != '0) ? SCAN : NONE;
          end
        end
        SCAN: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          out_code  = idx;
          out_last  = onehot;
          if (out_ready) begin
            pending_nxt = pending & ~(N'(1) << idx);
            if (onehot) state_nxt = IDLE;
          end
        end
        NONE: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          out_none  = 1'b1;
          out_code  = W'(ENC_CODE_NONE);
          out_last  = 1'b1;
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_serial_multi_hot.sv
// tb/tb_encoder_serial_multi_hot.sv - randomized self-checking bench against a set-bit list model
module tb_encoder_serial_multi_hot;

  localparam int N = 8;
  localparam int W = 3;

  typedef int int_q_t[$];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_code;
  logic         out_last;
  logic         out_none;
  logic         busy;

  int checks = 0;
  int failures = 0;

  encoder_serial_multi_hot #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: list of set-bit indices in emission order.
  function automatic int_q_t model_codes(input logic [N-1:0] v);
    int_q_t q;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef ENCODER_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
    return q;
  endfunction

  task automatic capture(input logic [N-1:0] v);
    @(negedge clk);
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_vec = v;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL capture_ready got in_ready=%b out_valid=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  // Streams out every expected beat; en/out_ready either random or a fixed hold/gap pattern.
  task automatic drain(input logic [N-1:0] v, input bit rnd, input int hold_n,
                       input int gap_at, input int gap_len);
    int_q_t q;
    bit     none;
    int     cyc;
    int     e;
    q = model_codes(v);
    none = (v == '0);
    if (none) q.push_back(0);
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      if (rnd) begin
        out_ready = ($urandom_range(3) != 0);
        en        = ($urandom_range(6) != 0);
        in_valid  = $urandom_range(1);
        in_vec    = N'($urandom);
      end else begin
        out_ready = (cyc >= hold_n);
        en        = !(cyc >= gap_at && cyc < gap_at + gap_len);
        in_valid  = 1'b0;
      end
      #1;
      checks++;
      if (en) begin
        e = q[0];
        if (out_valid !== 1'b1 || out_code !== W'(e) || out_last !== (q.size() == 1) ||
            out_none !== none || busy !== 1'b1 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL beat vec=%b cyc=%0d got v=%b code=%0d last=%b none=%b busy=%b rdy=%b exp 1 %0d %b %b 1 0",
                   v, cyc, out_valid, out_code, out_last, out_none, busy, in_ready, e, q.size() == 1, none);
        end
        if (out_ready) void'(q.pop_front());
      end else begin
        if ({in_ready, out_valid, out_code, out_last, out_none, busy} !== '0) begin
          failures++;
          $display("FAIL en_gate got rdy=%b v=%b code=%0d last=%b none=%b busy=%b exp all 0",
                   in_ready, out_valid, out_code, out_last, out_none, busy);
        end
      end
      cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout vec=%b got %0d beats left exp 0", v, q.size());
    end
    @(negedge clk);
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle vec=%b got rdy=%b busy=%b v=%b exp 1 0 0", v, in_ready, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_code, out_last, out_none, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b code=%0d last=%b none=%b busy=%b exp all 0",
               in_ready, out_valid, out_code, out_last, out_none, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    capture(8'b1010_0100);
    drain(8'b1010_0100, 1'b0, 0, 1000, 0);
  endtask

  task automatic test_none();
    capture(8'b0000_0000);
    drain(8'b0000_0000, 1'b0, 0, 1000, 0);
  endtask

  task automatic test_backpressure();
    capture(8'b1000_0001);
    drain(8'b1000_0001, 1'b0, 3, 1000, 0);
  endtask

  task automatic test_enable_gap();
    capture(8'b0001_1000);
    drain(8'b0001_1000, 1'b0, 0, 1, 2);
  endtask

  task automatic test_reset_midscan();
    int_q_t q;
    int     e;
    q = model_codes(8'b1111_1111);
    capture(8'b1111_1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      #1;
      e = q[i];
      checks++;
      if (out_valid !== 1'b1 || out_code !== W'(e) || out_last !== 1'b0) begin
        failures++;
        $display("FAIL midscan_beat%0d got v=%b code=%0d last=%b exp 1 %0d 0", i, out_valid, out_code, out_last, e);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_code, out_last, out_none, busy} !== '0) begin
      failures++;
      $display("FAIL midscan_reset got rdy=%b v=%b code=%0d last=%b none=%b busy=%b exp all 0",
               in_ready, out_valid, out_code, out_last, out_none, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midscan_release got rdy=%b busy=%b exp 1 0", in_ready, busy);
    end
    capture(8'b0100_0000);
    drain(8'b0100_0000, 1'b0, 0, 1000, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3))
        0: v = '0;
        1: v = N'(1) << $urandom_range(N - 1);
        default: v = N'($urandom);
      endcase
      capture(v);
      drain(v, 1'b1, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_none();
    test_backpressure();
    test_enable_gap();
    test_reset_midscan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_serial_multi_hot.md
Name: encoder_serial_multi_hot

Overview:
- Companion to the team's decoder family: the encode direction. Accepts an N-bit multi-hot request vector and emits the binary index of every set bit, one per handshake beat, lowest index first.
- Enable-gated like the decoders: en=0 forces all outputs to 0 and freezes state.
- Sits between request-collection logic and a binary-indexed consumer, such as an arbiter queue or a register-select bus.

Parameters:
- N, default 8: input vector width; legal range is 2..64.
- W, default $clog2(N): output code width. Derived; do not override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; 0 gates all outputs to 0 and freezes state.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a new vector.
- in_vec  in  N  multi-hot request vector.
- out_valid  out  1  out_code is valid.
- out_ready  in  1  consumer accepts the beat.
- out_code  out  W  binary index of the current set bit.
- out_last  out  1  current beat is the final beat of this vector.
- out_none  out  1  captured vector was all-zero; single beat with out_code=0.
- busy  out  1  a vector is held, i.e. state is not IDLE.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, pending=0.
  - All outputs are 0, including in_ready.
  - Reset takes priority over every other event, including mid-scan. The partially emitted vector is discarded with no further beats.
- States: IDLE, SCAN, NONE.
- IDLE:
  - in_ready = en.
  - On in_valid & in_ready: pending <= in_vec.
  - Next state is SCAN if in_vec != 0, otherwise NONE.
- SCAN:
  - in_ready=0.
  - out_valid = en.
  - out_code = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
- NONE:
  - out_valid = en, out_none=1, out_code=0, out_last=1.
  - On handshake, go to IDLE.
- Beat handshake is out_valid & out_ready:
  - SCAN: clear the emitted bit in pending. If out_last=1, go to IDLE; otherwise stay in SCAN.
  - Without handshake, out_code, out_last and out_none hold stable while out_valid=1.
- Latency:
  - First beat is valid on the cycle after input capture.
  - One beat per cycle under continuous out_ready.
  - A vector with k set bits occupies k cycles. The next vector can be accepted on the cycle after the last beat, so throughput is k+1 cycles per vector.
- en=0:
  - in_ready, out_valid, out_code, out_last, out_none and busy all drive 0.
  - state and pending hold; an out_ready asserted while en=0 is ignored.
  - Scan resumes exactly where it stopped when en returns to 1.
- in_valid while busy is not accepted (in_ready=0); the upstream must hold in_vec.
- in_vec with bit N-1 set: out_code = N-1. No wrap; the code fits in W bits.
- out_code, out_last and out_none are combinational from state and pending (a priority-encode of pending); no output register.

Optional Feature:
- Macro ENCODER_MSB_FIRST_EN.
- Defined: beats are emitted highest set index first, i.e. out_code = index of the highest set bit of pending.
- Undefined (default): lowest index first.
- All handshake, out_last, out_none and timing rules are identical in both builds.

Decomposition:
- Shared package encoder_pkg holds:
  - state enum enc_state_t (IDLE, SCAN, NONE);
  - constants ENC_N_MAX=64 and ENC_CODE_NONE=0.
- One natural sub-module, priority_index_enc:
  - purely combinational, parameter N;
  - input vec[N], outputs idx[W] and onehot_only (exactly one bit set);
  - direction is selected by ENCODER_MSB_FIRST_EN.

Test Plan (N=8, W=3):
1. Capture 8'b1010_0100, out_ready=1 held, en=1 -> codes 2,5,7 on consecutive cycles; out_last=1 only on code 7; in_ready=1 on the following cycle.
2. Capture 8'b0000_0000 -> one beat with out_none=1, out_code=0, out_last=1, then IDLE.
3. Capture 8'b1000_0001 with out_ready=0 for 3 cycles -> out_code=0 held stable with out_valid=1; release -> codes 0, then 7 with out_last=1.
4. Capture 8'b0001_1000 and drop en for 2 cycles after the first beat -> all outputs 0 during the gap; after en=1, code 4 emitted with out_last=1; no beat lost or duplicated.
5. Capture 8'b1111_1111 and assert rst after the 3rd beat -> next cycle all outputs 0, busy=0; after rst releases, in_ready=1 and a new vector 8'b0100_0000 yields the single beat code 6 with out_last=1.
6. With ENCODER_MSB_FIRST_EN defined, capture 8'b1010_0100 -> codes 7,5,2; out_last=1 on code 2.
